// File: rtl/button_conditioner.sv
// Button conditioner: per-channel 2-flop synchroniser, debounce counter, clean level and press/release pulses.
// Optional auto-repeat on REPEAT_MASK channels when BUTTON_AUTOREPEAT_EN is defined.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no repeat activity; waiting for an accepted press
//   ST_DELAY  | button held; counting REPEAT_DELAY_CYCLES to the first repeat
//   ST_REPEAT | button still held; one repeat pulse every REPEAT_PERIOD_CYCLES
module button_conditioner #(
    parameter int unsigned            NUM_BUTTONS          = 4,
    parameter int unsigned            DEBOUNCE_CYCLES      = 1_000_000,
    parameter int unsigned            COUNTER_WIDTH        = 21,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK          = NUM_BUTTONS'(4'b1000),
    parameter int unsigned            REPEAT_DELAY_CYCLES  = 1_500_000,
    parameter int unsigned            REPEAT_PERIOD_CYCLES = 500_000
) (
    input  logic                   clock_50mhz,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_raw,
    output logic [NUM_BUTTONS-1:0] buttons_level,
    output logic [NUM_BUTTONS-1:0] buttons_pressed,
    output logic [NUM_BUTTONS-1:0] buttons_released
);

    localparam int unsigned MAX_DR    = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                                        DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int unsigned MAX_COUNT = (MAX_DR > REPEAT_PERIOD_CYCLES) ? MAX_DR : REPEAT_PERIOD_CYCLES;

    localparam logic [COUNTER_WIDTH-1:0] DEB_TC = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || $clog2(MAX_COUNT + 1) > COUNTER_WIDTH) begin : g_param_error
        $error("button_conditioner: DEBOUNCE_CYCLES < 2 or COUNTER_WIDTH too narrow");
    end

`ifdef BUTTON_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam logic [COUNTER_WIDTH-1:0] RD_TC = COUNTER_WIDTH'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] RP_TC = COUNTER_WIDTH'(REPEAT_PERIOD_CYCLES - 1);
`endif

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        logic                     sync1_q, sync2_q;
        logic                     level_q, level_d;
        logic                     pressed_q, pressed_d;
        logic                     released_q, released_d;
        logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
        logic                     accept;
        logic                     rep_fire;

        always_comb begin
            accept     = (sync2_q != level_q) && (cnt_q == DEB_TC);
            level_d    = level_q;
            cnt_d      = '0;
            pressed_d  = rep_fire;
            released_d = 1'b0;
            if (sync2_q != level_q) begin
                if (accept) begin
                    level_d    = ~level_q;
                    pressed_d  = ~level_q;
                    released_d = level_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Inversion at the input makes the synchroniser carry the active-high "pushed" sense.
        always_ff @(posedge clock_50mhz) begin
            if (!reset) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                level_q    <= 1'b0;
                cnt_q      <= '0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
            end else begin
                sync1_q    <= ~buttons_raw[i];
                sync2_q    <= sync1_q;
                level_q    <= level_d;
                cnt_q      <= cnt_d;
                pressed_q  <= pressed_d;
                released_q <= released_d;
            end
        end

        assign buttons_level[i]    = level_q;
        assign buttons_pressed[i]  = pressed_q;
        assign buttons_released[i] = released_q;

`ifdef BUTTON_AUTOREPEAT_EN
        if (REPEAT_MASK[i]) begin : g_rep
            rep_state_t               state_q;
            logic [COUNTER_WIDTH-1:0] rcnt_q;
            logic                     fall;

            assign fall = accept & level_q;

            // A falling level wins over a repeat due in the same cycle.
            always_ff @(posedge clock_50mhz) begin
                if (!reset || fall) begin
                    state_q <= ST_IDLE;
                    rcnt_q  <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            rcnt_q <= '0;
                            if (accept) state_q <= ST_DELAY;
                        end
                        ST_DELAY: begin
                            if (rcnt_q == RD_TC) begin
                                rcnt_q  <= '0;
                                state_q <= ST_REPEAT;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (rcnt_q == RP_TC) rcnt_q <= '0;
                            else                 rcnt_q <= rcnt_q + 1'b1;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            rcnt_q  <= '0;
                        end
                    endcase
                end
            end

            assign rep_fire = !fall &&
                              (((state_q == ST_DELAY)  && (rcnt_q == RD_TC)) ||
                               ((state_q == ST_REPEAT) && (rcnt_q == RP_TC)));
        end else begin : g_norep
            assign rep_fire = 1'b0;
        end
`else
        assign rep_fire = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
// Repeat expectations follow BUTTON_AUTOREPEAT_EN, matching the RTL build.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw;
    logic [3:0] level, pressed, released;

    int n_total = 0;
    int n_pass  = 0;

    button_conditioner #(
        .NUM_BUTTONS         (4),
        .DEBOUNCE_CYCLES     (8),
        .COUNTER_WIDTH       (8),
        .REPEAT_MASK         (4'b1000),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_PERIOD_CYCLES(5)
    ) dut (
        .clock_50mhz     (clk),
        .reset           (reset),
        .buttons_raw     (raw),
        .buttons_level   (level),
        .buttons_pressed (pressed),
        .buttons_released(released)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        int         n;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t vecs[$];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
        check({tag, " level"},    {28'd0, level},    {28'd0, l});
        check({tag, " pressed"},  {28'd0, pressed},  {28'd0, p});
        check({tag, " released"}, {28'd0, released}, {28'd0, r});
    endtask

    initial begin
        int p3[$];
        int p2[$];
        int exp3[$];

        // All four buttons pushed through reset: outputs stay 0, then re-accepted 10 cycles later.
        reset = 1'b0;
        raw   = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check_outs($sformatf("reset c%0d", c), 4'h0, 4'h0, 4'h0);
        end
        reset = 1'b1;
        tick(9);
        check_outs("post-reset 9", 4'h0, 4'h0, 4'h0);
        tick(1);
        check_outs("post-reset 10", 4'hF, 4'hF, 4'h0);
        tick(1);
        check_outs("post-reset 11", 4'hF, 4'h0, 4'h0);

        // Release all
        vecs.push_back('{4'b1111,  9, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{4'b1111,  1, 4'h0, 4'h0, 4'hF});
        vecs.push_back('{4'b1111,  1, 4'h0, 4'h0, 4'h0});
        // Clean press / release of bit 3
        vecs.push_back('{4'b0111,  9, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{4'b0111,  1, 4'h8, 4'h8, 4'h0});
        vecs.push_back('{4'b0111,  1, 4'h8, 4'h0, 4'h0});
        vecs.push_back('{4'b0111,  4, 4'h8, 4'h0, 4'h0});
        vecs.push_back('{4'b1111,  9, 4'h8, 4'h0, 4'h0});
        vecs.push_back('{4'b1111,  1, 4'h0, 4'h0, 4'h8});
        vecs.push_back('{4'b1111,  1, 4'h0, 4'h0, 4'h0});
        // Bounce on bit 1: low 5, high 2, then low steadily
        vecs.push_back('{4'b1101,  5, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{4'b1111,  2, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{4'b1101,  9, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{4'b1101,  1, 4'h2, 4'h2, 4'h0});
        vecs.push_back('{4'b1101,  1, 4'h2, 4'h0, 4'h0});
        vecs.push_back('{4'b1111, 10, 4'h0, 4'h0, 4'h2});
        vecs.push_back('{4'b1111,  1, 4'h0, 4'h0, 4'h0});
        // Bits 0 and 2 together
        vecs.push_back('{4'b1010,  9, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{4'b1010,  1, 4'h5, 4'h5, 4'h0});
        vecs.push_back('{4'b1010,  1, 4'h5, 4'h0, 4'h0});
        vecs.push_back('{4'b1111, 10, 4'h0, 4'h0, 4'h5});
        vecs.push_back('{4'b1111,  1, 4'h0, 4'h0, 4'h0});

        for (int v = 0; v < vecs.size(); v++) begin
            raw = vecs[v].raw;
            tick(vecs[v].n);
            check_outs($sformatf("row%0d", v), vecs[v].lvl, vecs[v].prs, vecs[v].rel);
        end

        // Hold bits 3 and 2; release timed so the accepted release lands on a due repeat (tick 55).
        raw = 4'b0011;
`ifdef BUTTON_AUTOREPEAT_EN
        exp3 = '{10, 30, 35, 40, 45, 50};
`else
        exp3 = '{10};
`endif
        for (int t = 1; t <= 70; t++) begin
            tick(1);
            if (pressed[3]) p3.push_back(t);
            if (pressed[2]) p2.push_back(t);
            if (t == 55) begin
                check("release-on-due released", {28'd0, released}, 32'hC);
                check("release-on-due pressed",  {28'd0, pressed},  32'h0);
                check("release-on-due level",    {28'd0, level},    32'h0);
            end
            if (t == 45) raw = 4'b1111;
        end
        check("bit3 pulse count", p3.size(), exp3.size());
        for (int k = 0; k < exp3.size() && k < p3.size(); k++)
            check($sformatf("bit3 pulse %0d tick", k), p3[k], exp3[k]);
        check("bit2 pulse count", p2.size(), 1);
        if (p2.size() > 0) check("bit2 pulse tick", p2[0], 10);

        // Reset mid-debounce discards progress; held button re-accepted 10 cycles after reset.
        raw = 4'b1110;
        tick(6);
        reset = 1'b0;
        tick(1);
        check_outs("mid-debounce reset", 4'h0, 4'h0, 4'h0);
        reset = 1'b1;
        tick(9);
        check_outs("re-accept 9", 4'h0, 4'h0, 4'h0);
        tick(1);
        check_outs("re-accept 10", 4'h1, 4'h1, 4'h0);
        raw = 4'b1111;
        tick(10);
        check_outs("final release", 4'h0, 4'h0, 4'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
